// File: rtl/neuron_layer3_pkg.sv
// Shared types and helpers for the layer-3 neuron update engine:
// FSM encoding, width-derived clamp limits and the common saturate function.
package neuron_layer3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LEAK  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Working width for clamp arithmetic; every operand is sign-extended to this.
    localparam int SAT_CALC_W = 32;

    function automatic logic signed [SAT_CALC_W-1:0] sat_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [SAT_CALC_W-1:0] sat_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [SAT_CALC_W-1:0] saturate(
        input logic signed [SAT_CALC_W-1:0] v,
        input int                           w
    );
        logic signed [SAT_CALC_W-1:0] r;
        if (v > sat_max(w)) begin
            r = sat_max(w);
        end else if (v < sat_min(w)) begin
            r = sat_min(w);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_update_engine_layer3_sat_adder.sv
// neuron_sat_adder: signed add of two operands of any width, clamped into OUT_W.
// Purely combinational; callers register the result.
module neuron_sat_adder
    import neuron_layer3_pkg::*;
#(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int OUT_W = 16
) (
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [OUT_W-1:0] y_o
);

    logic signed [SAT_CALC_W-1:0] sum_s;

    // Sign-extend both operands, add without wrap, then clamp into the output range.
    always_comb begin
        sum_s = SAT_CALC_W'(a_i) + SAT_CALC_W'(b_i);
        y_o   = OUT_W'(saturate(sum_s, OUT_W));
    end

endmodule

// File: rtl/neuron_update_engine_layer3.sv
// Layer-3 neuron update engine: accumulate weights onto the membrane, leak, clamp,
// threshold and emit write/spike strobes. Optional refractory: NEURON_REFRACTORY_EN.
module neuron_update_engine_layer3
    import neuron_layer3_pkg::*;
#(
    parameter int BIT_WIDTH_MEMBRANE     = 16,
    parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
    parameter int BIT_WIDTH_WEIGHT       = 8,
    parameter int ACC_GUARD              = 4,
    parameter int LEAK_SHIFT             = 3
`ifdef NEURON_REFRACTORY_EN
    ,
    parameter int REFRACTORY_STEPS       = 2
`endif
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     step_start_i,
    input  logic signed [BIT_WIDTH_WEIGHT-1:0]       weight_i,
    input  logic                                     weight_valid_i,
    input  logic                                     weight_last_i,
    output logic                                     weight_ready_o,
    input  logic signed [BIT_WIDTH_MEMBRANE-1:0]     threshold_i,
    input  logic                                     leak_en_i,
    input  logic signed [BIT_WIDTH_MEMBRANE-1:0]     membrane_i,
    input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_membrane_i,
    output logic signed [BIT_WIDTH_MEMBRANE-1:0]     membrane_update_o,
    output logic                                     membrane_update_valid_o,
    output logic                                     post_spiking_now_o,
    output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_membrane_update_o,
    output logic                                     big_membrane_update_valid_o,
    output logic                                     step_done_o
);

    localparam int ACC_W = BIT_WIDTH_MEMBRANE + ACC_GUARD;

    state_e                               state_q, state_d;
    logic signed [ACC_W-1:0]              acc_q, acc_d;
    logic signed [ACC_W-1:0]              wsum_q, wsum_d;
    logic signed [BIT_WIDTH_MEMBRANE-1:0] mem_upd_q, mem_upd_d;
    logic                                 mem_valid_q, mem_valid_d;
    logic                                 spike_q, spike_d;
    logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_upd_q, big_upd_d;
    logic                                 big_valid_q, big_valid_d;
    logic                                 done_q, done_d;

    logic signed [ACC_W-1:0]              acc_leak_s;
    logic signed [BIT_WIDTH_MEMBRANE-1:0] mem_sat_s;
    logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_sat_s;
    logic                                 fire_s;

`ifdef NEURON_REFRACTORY_EN
    localparam int REFR_W = (REFRACTORY_STEPS < 1) ? 1 : $clog2(REFRACTORY_STEPS + 1);
    logic [REFR_W-1:0] refr_q, refr_d;
`endif

    // Leak term is evaluated on the live accumulator while in LEAK.
    always_comb begin
        if (leak_en_i) begin
            acc_leak_s = acc_q - (acc_q >>> LEAK_SHIFT);
        end else begin
            acc_leak_s = acc_q;
        end
    end

    neuron_sat_adder #(
        .A_W   (ACC_W),
        .B_W   (1),
        .OUT_W (BIT_WIDTH_MEMBRANE)
    ) u_mem_clamp (
        .a_i (acc_leak_s),
        .b_i (1'b0),
        .y_o (mem_sat_s)
    );

    neuron_sat_adder #(
        .A_W   (BIT_WIDTH_BIG_MEMBRANE),
        .B_W   (ACC_W),
        .OUT_W (BIT_WIDTH_BIG_MEMBRANE)
    ) u_big_sum (
        .a_i (big_membrane_i),
        .b_i (wsum_q),
        .y_o (big_sat_s)
    );

    assign fire_s = (mem_sat_s >= threshold_i);

    // Next-state and next-output logic; strobes are computed in LEAK so they
    // appear registered during the WRITE cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        wsum_d      = wsum_q;
        mem_upd_d   = '0;
        mem_valid_d = 1'b0;
        spike_d     = 1'b0;
        big_upd_d   = '0;
        big_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef NEURON_REFRACTORY_EN
        refr_d      = refr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (step_start_i) begin
                    acc_d   = ACC_W'(membrane_i);
                    wsum_d  = '0;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (weight_valid_i) begin
                    acc_d  = acc_q + ACC_W'(weight_i);
                    wsum_d = wsum_q + ACC_W'(weight_i);
                    if (weight_last_i) begin
                        state_d = ST_LEAK;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_LEAK: begin
                acc_d       = acc_leak_s;
                big_upd_d   = big_sat_s;
                big_valid_d = 1'b1;
                done_d      = 1'b1;
                state_d     = ST_WRITE;
`ifdef NEURON_REFRACTORY_EN
                if (refr_q != '0) begin
                    refr_d      = refr_q - REFR_W'(1);
                    mem_valid_d = 1'b1;
                    mem_upd_d   = '0;
                end else if (fire_s) begin
                    spike_d = 1'b1;
                    refr_d  = REFR_W'(REFRACTORY_STEPS);
                end else begin
                    mem_valid_d = 1'b1;
                    mem_upd_d   = mem_sat_s;
                end
`else
                if (fire_s) begin
                    spike_d = 1'b1;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_upd_d   = mem_sat_s;
                end
`endif
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            wsum_q      <= '0;
            mem_upd_q   <= '0;
            mem_valid_q <= 1'b0;
            spike_q     <= 1'b0;
            big_upd_q   <= '0;
            big_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef NEURON_REFRACTORY_EN
            refr_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            wsum_q      <= wsum_d;
            mem_upd_q   <= mem_upd_d;
            mem_valid_q <= mem_valid_d;
            spike_q     <= spike_d;
            big_upd_q   <= big_upd_d;
            big_valid_q <= big_valid_d;
            done_q      <= done_d;
`ifdef NEURON_REFRACTORY_EN
            refr_q      <= refr_d;
`endif
        end
    end

    assign weight_ready_o              = (state_q == ST_ACCUM);
    assign membrane_update_o           = mem_upd_q;
    assign membrane_update_valid_o     = mem_valid_q;
    assign post_spiking_now_o          = spike_q;
    assign big_membrane_update_o       = big_upd_q;
    assign big_membrane_update_valid_o = big_valid_q;
    assign step_done_o                 = done_q;

endmodule
